// File: rtl/pb_pkg.sv
// Shared types and default parameters for the push-button conditioner.
// The repeat FSM state encoding is visible on the top-level debug output.
package pb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } pb_state_t;

    localparam int DEF_NUM_PB       = 4;
    localparam int DEF_SAMPLE_DIV   = 50000;
    localparam int DEF_SHIFT_DEPTH  = 8;
    localparam int DEF_HOLD_TICKS   = 500;
    localparam int DEF_REPEAT_TICKS = 100;

    // Counter width for a terminal count of n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pb_channel.sv
// One button: two-flop synchronizer, sample-history debounce, registered
// level/edge pulses and a keyboard-style auto-repeat FSM advanced on tick.
module pb_channel
    import pb_pkg::*;
#(
    parameter int SHIFT_DEPTH  = DEF_SHIFT_DEPTH,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       pb_raw,
    output logic       level,
    output logic       pushed,
    output logic       released,
    output logic       pb_event,
    output logic [1:0] state_dbg
);

    localparam int HW = cnt_width(HOLD_TICKS);
    localparam int RW = cnt_width(REPEAT_TICKS);
    localparam int CW = (HW > RW) ? HW : RW;
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

    logic                   sync0, sync1, sync_val;
    logic [SHIFT_DEPTH-1:0] hist, hist_next;
    logic                   level_next, rise, fall;
    pb_state_t              state, state_next;
    logic [CW-1:0]          cnt, cnt_next;
    logic                   event_d;

    // Raw pins idle high; the synchronizer resets to "released".
    assign sync_val = ~sync1;

    always_comb begin
        hist_next  = hist;
        level_next = level;
        if (tick) begin
            hist_next = {hist[SHIFT_DEPTH-2:0], sync_val};
            if (&hist_next)
                level_next = 1'b1;
            else if (~|hist_next)
                level_next = 1'b0;
        end
    end

    assign rise = level_next & ~level;
    assign fall = ~level_next & level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0    <= 1'b1;
            sync1    <= 1'b1;
            hist     <= '0;
            level    <= 1'b0;
            pushed   <= 1'b0;
            released <= 1'b0;
            pb_event <= 1'b0;
        end else begin
            sync0    <= pb_raw;
            sync1    <= sync0;
            hist     <= hist_next;
            level    <= level_next;
            pushed   <= rise;
            released <= fall;
            pb_event <= event_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A fall always beats a coincident hold/repeat expiry.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_next = S_HOLD;
                    cnt_next   = '0;
                end
            end
            S_HOLD: begin
                if (fall) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt == HOLD_LAST) begin
                        state_next = S_REPEAT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            S_REPEAT: begin
                if (fall) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (tick) begin
                    if (cnt == REPEAT_LAST)
                        cnt_next = '0;
                    else
                        cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        event_d = 1'b0;
        case (state)
            S_IDLE:   event_d = rise;
            S_HOLD:   event_d = !fall && tick && (cnt == HOLD_LAST);
            S_REPEAT: event_d = !fall && tick && (cnt == REPEAT_LAST);
            default:  event_d = 1'b0;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: rtl/pb_debounce_repeat.sv
// Push-button conditioner: shared sample-tick generator feeding one
// debounce/auto-repeat channel per button.
module pb_debounce_repeat
    import pb_pkg::*;
#(
    parameter int NUM_PB       = DEF_NUM_PB,
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
    parameter int SHIFT_DEPTH  = DEF_SHIFT_DEPTH,
    parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic                Clock_50,
    input  logic                Resetn,
    input  logic [NUM_PB-1:0]   PB_signal_I,
    output logic [NUM_PB-1:0]   PB_level_O,
    output logic [NUM_PB-1:0]   PB_pushed_O,
    output logic [NUM_PB-1:0]   PB_released_O,
    output logic [NUM_PB-1:0]   PB_event_O,
    output logic [2*NUM_PB-1:0] PB_state_O
);

    localparam int            TW        = cnt_width(SAMPLE_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
        pb_channel #(
            .SHIFT_DEPTH  (SHIFT_DEPTH),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_ch (
            .clk       (Clock_50),
            .rst_n     (Resetn),
            .tick      (tick),
            .pb_raw    (PB_signal_I[g]),
            .level     (PB_level_O[g]),
            .pushed    (PB_pushed_O[g]),
            .released  (PB_released_O[g]),
            .pb_event  (PB_event_O[g]),
            .state_dbg (PB_state_O[2*g +: 2])
        );
    end

endmodule

// File: tb/tb_pb_debounce_repeat.sv
// Directed bench for pb_debounce_repeat with small parameters
// (one sample tick = 4 clocks, 4-sample debounce, hold 10, repeat 3).
module tb_pb_debounce_repeat;
    import pb_pkg::*;

    localparam int NUM_PB       = 4;
    localparam int SAMPLE_DIV   = 4;
    localparam int SHIFT_DEPTH  = 4;
    localparam int HOLD_TICKS   = 10;
    localparam int REPEAT_TICKS = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NUM_PB-1:0]   pb_in = '1;
    logic [NUM_PB-1:0]   level, pushed, released, pb_event;
    logic [2*NUM_PB-1:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    int cyc = 0;
    int push_cnt[NUM_PB] = '{default: 0};
    int rel_cnt[NUM_PB]  = '{default: 0};
    int ev_cnt[NUM_PB]   = '{default: 0};
    int push_time[NUM_PB] = '{default: 0};
    int viol = 0;
    int ev2_q[$];
    int rel3_q[$];

    pb_debounce_repeat #(
        .NUM_PB       (NUM_PB),
        .SAMPLE_DIV   (SAMPLE_DIV),
        .SHIFT_DEPTH  (SHIFT_DEPTH),
        .HOLD_TICKS   (HOLD_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .Clock_50      (clk),
        .Resetn        (rst_n),
        .PB_signal_I   (pb_in),
        .PB_level_O    (level),
        .PB_pushed_O   (pushed),
        .PB_released_O (released),
        .PB_event_O    (pb_event),
        .PB_state_O    (state)
    );

    // ---- clock ----
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- pulse monitor, sampled on the falling edge ----
    always @(negedge clk) begin
        for (int b = 0; b < NUM_PB; b++) begin
            if (pushed[b]) begin
                push_cnt[b]++;
                push_time[b] = cyc;
            end
            if (released[b]) rel_cnt[b]++;
            if (pb_event[b]) ev_cnt[b]++;
        end
        if (pb_event[2]) ev2_q.push_back(cyc);
        if (released[3]) rel3_q.push_back(cyc);
        if ((pushed & ~level) != '0 || (released & level) != '0 || (pushed & released) != '0)
            viol++;
    end

    function automatic int total_pulses();
        int s = 0;
        for (int b = 0; b < NUM_PB; b++) s += push_cnt[b] + rel_cnt[b] + ev_cnt[b];
        return s;
    endfunction

    task automatic wait_level(input int b, input logic val, input int max_clk, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_clk; i++) begin
            @(negedge clk);
            if (level[b] === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---- tests ----
    task automatic test_reset();
        int t0;
        rst_n = 1'b0;
        pb_in = '1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (level !== '0) begin tests_failed++; $display("FAIL reset_level: got %b expected 0000", level); end
        tests_run++;
        if (pushed !== '0 || released !== '0 || pb_event !== '0) begin
            tests_failed++; $display("FAIL reset_pulses: got %b/%b/%b expected all 0", pushed, released, pb_event);
        end
        tests_run++;
        if (state !== '0) begin tests_failed++; $display("FAIL reset_state: got %h expected 00", state); end
        rst_n = 1'b1;
        t0 = total_pulses();
        repeat (100) @(negedge clk);
        tests_run++;
        if (total_pulses() - t0 != 0) begin
            tests_failed++; $display("FAIL idle_no_pulses: got %0d pulses expected 0", total_pulses() - t0);
        end
        tests_run++;
        if (level !== '0) begin tests_failed++; $display("FAIL idle_level: got %b expected 0000", level); end
    endtask

    task automatic test_press();
        int p0, e0, r0;
        bit ok;
        p0 = push_cnt[0]; e0 = ev_cnt[0]; r0 = rel_cnt[0];
        pb_in[0] = 1'b0;
        wait_level(0, 1'b1, 22, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL press_latency: level[0]=%b expected 1 within 22 clocks", level[0]); end
        repeat (8) @(negedge clk);
        pb_in[0] = 1'b1;
        wait_level(0, 1'b0, 24, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL release_latency: level[0]=%b expected 0 within 24 clocks", level[0]); end
        repeat (4) @(negedge clk);
        tests_run++;
        if (push_cnt[0] - p0 != 1) begin tests_failed++; $display("FAIL press_pushed: got %0d clocks expected 1", push_cnt[0] - p0); end
        tests_run++;
        if (ev_cnt[0] - e0 != 1) begin tests_failed++; $display("FAIL press_event: got %0d clocks expected 1", ev_cnt[0] - e0); end
        tests_run++;
        if (rel_cnt[0] - r0 != 1) begin tests_failed++; $display("FAIL press_released: got %0d clocks expected 1", rel_cnt[0] - r0); end
    endtask

    task automatic test_glitch();
        int t0;
        t0 = total_pulses();
        pb_in[1] = 1'b0;
        repeat (10) @(negedge clk);
        pb_in[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            tests_run++;
            if (level[1] !== 1'b0) begin
                tests_failed++; $display("FAIL glitch_level: got %b expected 0 at clock %0d", level[1], i);
                break;
            end
        end
        tests_run++;
        if (total_pulses() - t0 != 0) begin
            tests_failed++; $display("FAIL glitch_pulses: got %0d pulses expected 0", total_pulses() - t0);
        end
    endtask

    task automatic test_hold_repeat();
        int x, s0, p0, r0, fall_cyc;
        int exp_off[4] = '{0, 40, 52, 64};
        bit ok;
        s0 = ev2_q.size(); p0 = push_cnt[2]; r0 = rel_cnt[2];
        pb_in[2] = 1'b0;
        wait_level(2, 1'b1, 22, ok);
        x = cyc;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL hold_press: level[2]=%b expected 1 within 22 clocks", level[2]); end
        tests_run++;
        if (state[5:4] !== S_HOLD) begin tests_failed++; $display("FAIL hold_state: got %0d expected %0d", state[5:4], S_HOLD); end
        repeat (53) @(negedge clk);
        pb_in[2] = 1'b1;
        wait_level(2, 1'b0, 24, ok);
        fall_cyc = cyc;
        tests_run++;
        if (!ok || fall_cyc - x != 68) begin
            tests_failed++; $display("FAIL hold_fall: got offset %0d (ok=%0d) expected 68", fall_cyc - x, ok);
        end
        repeat (8) @(negedge clk);
        tests_run++;
        if (ev2_q.size() - s0 != 4) begin
            tests_failed++; $display("FAIL hold_event_count: got %0d expected 4", ev2_q.size() - s0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (ev2_q[s0 + i] - x != exp_off[i]) begin
                    tests_failed++; $display("FAIL hold_event_time%0d: got offset %0d expected %0d", i, ev2_q[s0 + i] - x, exp_off[i]);
                end
            end
        end
        tests_run++;
        if (push_cnt[2] - p0 != 1) begin tests_failed++; $display("FAIL hold_pushed: got %0d expected 1", push_cnt[2] - p0); end
        tests_run++;
        if (rel_cnt[2] - r0 != 1) begin tests_failed++; $display("FAIL hold_released: got %0d expected 1", rel_cnt[2] - r0); end
    endtask

    task automatic test_fall_vs_repeat();
        int x, e0, s0;
        bit ok;
        e0 = ev_cnt[3]; s0 = rel3_q.size();
        pb_in[3] = 1'b0;
        wait_level(3, 1'b1, 22, ok);
        x = cyc;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL tie_press: level[3]=%b expected 1 within 22 clocks", level[3]); end
        repeat (49) @(negedge clk);
        pb_in[3] = 1'b1;
        wait_level(3, 1'b0, 24, ok);
        repeat (6) @(negedge clk);
        tests_run++;
        if (rel3_q.size() - s0 != 1 || rel3_q[rel3_q.size() - 1] - x != 64) begin
            tests_failed++; $display("FAIL tie_released: got %0d pulses last offset %0d expected 1 at 64",
                                     rel3_q.size() - s0, (rel3_q.size() > 0) ? rel3_q[rel3_q.size() - 1] - x : -1);
        end
        tests_run++;
        if (ev_cnt[3] - e0 != 3) begin tests_failed++; $display("FAIL tie_event_count: got %0d expected 3", ev_cnt[3] - e0); end
        tests_run++;
        if (state[7:6] !== S_IDLE) begin tests_failed++; $display("FAIL tie_state: got %0d expected %0d", state[7:6], S_IDLE); end
        tests_run++;
        if (level[3] !== 1'b0) begin tests_failed++; $display("FAIL tie_level: got %b expected 0", level[3]); end
    endtask

    task automatic test_reset_mid();
        int n, p0[NUM_PB], r0[NUM_PB], e0[NUM_PB];
        bit ok;
        pb_in[0] = 1'b0;
        wait_level(0, 1'b1, 22, ok);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (level !== '0 || pushed !== '0 || pb_event !== '0 || state !== '0) begin
            tests_failed++; $display("FAIL midreset_clear: got lvl=%b push=%b ev=%b st=%h expected all 0", level, pushed, pb_event, state);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (pushed[0] === 1'b1) begin
                n = i;
                break;
            end
        end
        tests_run++;
        if (n != 16) begin tests_failed++; $display("FAIL midreset_repress: got pushed at clock %0d expected 16", n); end
        tests_run++;
        if (pb_event[0] !== 1'b1) begin tests_failed++; $display("FAIL midreset_event: got %b expected 1", pb_event[0]); end
        pb_in[0] = 1'b1;
        wait_level(0, 1'b0, 24, ok);
        repeat (8) @(negedge clk);

        for (int b = 0; b < NUM_PB; b++) begin p0[b] = push_cnt[b]; r0[b] = rel_cnt[b]; e0[b] = ev_cnt[b]; end
        pb_in = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (level === 4'b1110) begin ok = 1'b1; break; end
        end
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL multi_level: got %b expected 1110", level); end
        pb_in = 4'b1111;
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (level === 4'b0000) begin ok = 1'b1; break; end
        end
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL multi_release: got %b expected 0000", level); end
        repeat (4) @(negedge clk);
        for (int b = 1; b < NUM_PB; b++) begin
            tests_run++;
            if (push_cnt[b] - p0[b] != 1 || rel_cnt[b] - r0[b] != 1 || ev_cnt[b] - e0[b] != 1) begin
                tests_failed++; $display("FAIL multi_pulses%0d: got push=%0d rel=%0d ev=%0d expected 1/1/1",
                                         b, push_cnt[b] - p0[b], rel_cnt[b] - r0[b], ev_cnt[b] - e0[b]);
            end
        end
        tests_run++;
        if (push_time[1] != push_time[2] || push_time[2] != push_time[3]) begin
            tests_failed++; $display("FAIL multi_same_clock: got %0d/%0d/%0d expected equal", push_time[1], push_time[2], push_time[3]);
        end
        tests_run++;
        if (push_cnt[0] - p0[0] != 0 || ev_cnt[0] - e0[0] != 0) begin
            tests_failed++; $display("FAIL multi_bit0_quiet: got push=%0d ev=%0d expected 0/0", push_cnt[0] - p0[0], ev_cnt[0] - e0[0]);
        end
    endtask

    task automatic test_invariants();
        tests_run++;
        if (viol != 0) begin tests_failed++; $display("FAIL pulse_invariants: got %0d violating clocks expected 0", viol); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_hold_repeat();
        test_fall_vs_repeat();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
